// File: rtl/avg_downsamp.sv
// Decimating boxcar downsampler: sums 2**SAMPLE_RATE signed samples per frame and
// strobes out_en for one cycle per frame. Optional macro DS_DROP_CNT_EN enables drop_cnt.
module avg_downsamp #(
    parameter int unsigned DATA_WIDTH  = 14,
    parameter int unsigned SAMPLE_RATE = 2
) (
    input  logic                                clk,
    input  logic                                rst_in,
    input  logic [DATA_WIDTH-1:0]               dataIn,
    input  logic                                in_en,
    input  logic                                outbusy,
    input  logic                                fifo_almst_full,
    output logic [DATA_WIDTH+SAMPLE_RATE-1:0]   dsoutdata,
    output logic                                out_en,
    output logic [15:0]                         drop_cnt
);

    localparam int unsigned OW = DATA_WIDTH + SAMPLE_RATE;
    localparam int unsigned CW = (SAMPLE_RATE > 0) ? SAMPLE_RATE : 1;
    localparam logic [CW-1:0] LAST = CW'((2 ** SAMPLE_RATE) - 1);

    typedef enum logic {
        S_IDLE,
        S_RUN
    } state_t;

    state_t                r_state;
    logic signed [OW-1:0]  r_acc;
    logic [CW-1:0]         r_cnt;
    logic [OW-1:0]         r_out;
    logic                  r_oe;

    logic signed [OW-1:0]  w_x;
    logic signed [OW-1:0]  w_sum;
    logic                  w_last;

    // Sign extension makes the frame sum exact: OW bits hold 2**SAMPLE_RATE full-scale samples.
    assign w_x    = OW'($signed(dataIn));
    assign w_sum  = r_acc + w_x;
    assign w_last = (r_cnt == LAST);

    always_ff @(posedge clk or negedge rst_in) begin
        if (!rst_in) begin
            r_state <= S_IDLE;
            r_acc   <= '0;
            r_cnt   <= '0;
            r_out   <= '0;
            r_oe    <= 1'b0;
        end else begin
            r_oe <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_acc <= '0;
                    r_cnt <= '0;
                    if (!outbusy) begin
                        r_state <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (outbusy) begin
                        // Partial frame is discarded; outbusy also beats a coincident last sample.
                        r_state <= S_IDLE;
                        r_acc   <= '0;
                        r_cnt   <= '0;
                    end else if (in_en) begin
                        if (!w_last) begin
                            r_acc <= w_sum;
                            r_cnt <= r_cnt + CW'(1);
                        end else begin
                            r_acc <= '0;
                            r_cnt <= '0;
                            if (!fifo_almst_full) begin
                                r_out <= w_sum;
                                r_oe  <= 1'b1;
                            end
                        end
                    end
                end
            endcase
        end
    end

    assign dsoutdata = r_out;
    assign out_en    = r_oe;

`ifdef DS_DROP_CNT_EN
    logic        w_drop;
    logic [15:0] r_drop_cnt;

    assign w_drop = (r_state == S_RUN) && !outbusy && in_en && w_last && fifo_almst_full;

    // Saturating count of frames lost to FIFO back-pressure.
    always_ff @(posedge clk or negedge rst_in) begin
        if (!rst_in) begin
            r_drop_cnt <= 16'd0;
        end else if (w_drop && (r_drop_cnt != 16'hFFFF)) begin
            r_drop_cnt <= r_drop_cnt + 16'd1;
        end
    end

    assign drop_cnt = r_drop_cnt;
`else
    assign drop_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_avg_downsamp.sv
// Directed scoreboard bench for avg_downsamp: SAMPLE_RATE=2 instance plus a
// SAMPLE_RATE=0 pass-through instance.
module tb_avg_downsamp;

    logic        clk;
    logic        rst_n;
    logic [13:0] dataIn;
    logic        in_en;
    logic        outbusy;
    logic        fafull;
    logic [15:0] dsout;
    logic        out_en;
    logic [15:0] drop_cnt;

    logic [13:0] dataIn1;
    logic        in_en1;
    logic [13:0] dsout1;
    logic        out_en1;
    logic [15:0] drop_cnt1;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    logic [15:0] exp_q[$];
    int          oe_times[$];

    avg_downsamp #(.DATA_WIDTH(14), .SAMPLE_RATE(2)) u_dut (
        .clk(clk), .rst_in(rst_n), .dataIn(dataIn), .in_en(in_en),
        .outbusy(outbusy), .fifo_almst_full(fafull),
        .dsoutdata(dsout), .out_en(out_en), .drop_cnt(drop_cnt)
    );

    avg_downsamp #(.DATA_WIDTH(14), .SAMPLE_RATE(0)) u_dut0 (
        .clk(clk), .rst_in(rst_n), .dataIn(dataIn1), .in_en(in_en1),
        .outbusy(1'b0), .fifo_almst_full(1'b0),
        .dsoutdata(dsout1), .out_en(out_en1), .drop_cnt(drop_cnt1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Scoreboard: every out_en pulse must match the oldest pending expected sum.
    always @(negedge clk) begin
        if (rst_n && out_en) begin
            oe_times.push_back(cyc);
            if (exp_q.size() == 0) begin
                check("unexpected_out_en", 32'(dsout), 32'hDEAD_BEEF);
            end else begin
                check("frame_sum", 32'(dsout), 32'(exp_q.pop_front()));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic smp(input int v);
        dataIn = 14'(v);
        in_en  = 1'b1;
        tick();
        in_en  = 1'b0;
    endtask

    initial begin
        int n0;
        int s;
        rst_n   = 1'b0;
        dataIn  = '0;
        in_en   = 1'b0;
        outbusy = 1'b0;
        fafull  = 1'b0;
        dataIn1 = '0;
        in_en1  = 1'b0;
        tick();
        tick();
        check("rst_dsout", 32'(dsout), 32'd0);
        check("rst_out_en", 32'(out_en), 32'd0);
        check("rst_drop_cnt", 32'(drop_cnt), 32'd0);
        rst_n = 1'b1;
        tick();
        tick();

        // Basic frame, latency one clock, single-cycle strobe.
        smp(100); smp(200); smp(300);
        check("no_early_oe", 32'(out_en), 32'd0);
        exp_q.push_back(16'd1000);
        smp(400);
        check("oe_after_last", 32'(out_en), 32'd1);
        tick();
        check("oe_one_cycle", 32'(out_en), 32'd0);
        check("dsout_held", 32'(dsout), 32'd1000);

        // Full-scale extremes.
        for (int i = 0; i < 4; i++) begin
            if (i == 3) exp_q.push_back(16'h8000);
            dataIn = 14'h2000; in_en = 1'b1; tick();
        end
        for (int i = 0; i < 4; i++) begin
            if (i == 3) exp_q.push_back(16'h7FFC);
            dataIn = 14'h1FFF; in_en = 1'b1; tick();
        end
        in_en = 1'b0;
        tick();

        // Continuous 12-sample stream: three pulses 4 clocks apart.
        n0 = oe_times.size();
        s  = 0;
        for (int i = 0; i < 12; i++) begin
            s += i * 37 - 200;
            if ((i % 4) == 3) begin
                exp_q.push_back(16'(s));
                s = 0;
            end
            dataIn = 14'(i * 37 - 200);
            in_en  = 1'b1;
            tick();
        end
        in_en = 1'b0;
        tick();
        check("stream_pulses", 32'(oe_times.size() - n0), 32'd3);
        if (oe_times.size() - n0 == 3) begin
            check("stream_gap1", 32'(oe_times[n0+1] - oe_times[n0]), 32'd4);
            check("stream_gap2", 32'(oe_times[n0+2] - oe_times[n0+1]), 32'd4);
        end

        // outbusy mid-frame discards partial frame.
        smp(50); smp(60);
        outbusy = 1'b1; tick();
        outbusy = 1'b0; tick();
        smp(1); smp(2); smp(3);
        exp_q.push_back(16'd10);
        smp(4);
        tick();
        check("busy_dsout", 32'(dsout), 32'd10);

        // outbusy coincident with last sample: no emit.
        smp(1); smp(1); smp(1);
        outbusy = 1'b1; smp(1);
        outbusy = 1'b0;
        check("busy_last_no_oe", 32'(out_en), 32'd0);
        tick();

        // FIFO almost full on last sample drops the frame but keeps alignment.
        smp(9); smp(9); smp(9);
        fafull = 1'b1; smp(9);
        fafull = 1'b0;
        check("drop_no_oe", 32'(out_en), 32'd0);
        check("drop_dsout_held", 32'(dsout), 32'd10);
`ifdef DS_DROP_CNT_EN
        check("drop_cnt", 32'(drop_cnt), 32'd1);
`else
        check("drop_cnt", 32'(drop_cnt), 32'd0);
`endif
        smp(5); smp(5); smp(5);
        exp_q.push_back(16'd20);
        smp(5);
        tick();

        // Pass-through instance: continuous out_en.
        dataIn1 = 14'd7; in_en1 = 1'b1; tick();
        check("pt_oe1", 32'(out_en1), 32'd1);
        check("pt_val1", 32'(dsout1), 32'd7);
        dataIn1 = 14'h3FFD; tick();
        check("pt_oe2", 32'(out_en1), 32'd1);
        check("pt_val2", 32'(dsout1), 32'h3FFD);
        in_en1 = 1'b0; tick();
        check("pt_oe_low", 32'(out_en1), 32'd0);

        // Asynchronous reset mid-stream, then framing restarts at zero.
        smp(11); smp(22);
        dataIn1 = 14'd5; in_en1 = 1'b1; tick();
        in_en1 = 1'b0;
        check("pt_oe3", 32'(out_en1), 32'd1);
        #1 rst_n = 1'b0;
        #1;
        check("arst_pt_oe", 32'(out_en1), 32'd0);
        check("arst_pt_dsout", 32'(dsout1), 32'd0);
        check("arst_dsout", 32'(dsout), 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        tick();
        smp(1); smp(2); smp(3);
        exp_q.push_back(16'd10);
        smp(4);
        tick();
        tick();
        check("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
